dsm_sample_feeder: RTL and testbench

//   Upstream stage of the delta-sigma loop. Accepts PCM samples over valid/ready, holds

---
 rtl/dsm_pkg.sv | 32 +++
 rtl/dsm_lfsr_dither.sv | 34 +++
 rtl/dsm_sample_feeder.sv | 171 +++++++++++++++++
 tb/tb_dsm_sample_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// -----------------------------------------------------------------------------
// dsm_pkg
//   Shared definitions for the delta-sigma modulator stages:
//     - dsm_state_t  : feeder control states (IDLE = no sample held, RUN = ticking)
//     - LFSR_SEED    : reset value of the dither LFSR
//     - LFSR_TAPS    : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//     - fb_pos/fb_neg: quantizer feedback levels for a given signed sample width
//   Valid sample widths for fb_pos/fb_neg are 2..31 bits.
// -----------------------------------------------------------------------------
package dsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsm_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Bits 15,13,12,10 correspond to polynomial taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Full-scale positive level: 2^(w-1)-1.
  function automatic logic signed [31:0] fb_pos(input int unsigned w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  // Full-scale negative level: -2^(w-1).
  function automatic logic signed [31:0] fb_neg(input int unsigned w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/dsm_lfsr_dither.sv
// -----------------------------------------------------------------------------
// dsm_lfsr_dither
//   16-bit Fibonacci LFSR producing a one-bit dither value. The register starts
//   at LFSR_SEED and shifts once per cycle in which i_en is high; o_dither is
//   the current LSB.
// Ports
//   i_clk     in  1  clock
//   i_rst_n   in  1  synchronous active-low reset (loads LFSR_SEED)
//   i_en      in  1  advance enable
//   o_dither  out 1  dither bit (LSB of the LFSR)
// -----------------------------------------------------------------------------
module dsm_lfsr_dither
  import dsm_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_dither
);

  logic [15:0] lfsr_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (i_en) begin
      // Shift left, XOR of the tapped bits enters at bit 0.
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign o_dither = lfsr_q[0];

endmodule

// File: rtl/dsm_sample_feeder.sv
// -----------------------------------------------------------------------------
// dsm_sample_feeder
//   Upstream stage of the delta-sigma loop. Accepts signed PCM samples over a
//   valid/ready handshake, holds each one for i_osr+1 modulator ticks and
//   presents the loop error (sample - quantizer feedback) to the integrator
//   together with a per-tick enable strobe. If a hold period ends without a
//   new sample, the held sample is repeated and a sticky underrun flag is set.
//
// Optional feature
//   DSM_FEEDER_DITHER_EN : when defined, a 16-bit LFSR (dsm_lfsr_dither) is
//                          advanced on every tick and its LSB is subtracted
//                          from o_data.
//
// Parameters
//   DATA_WIDTH  PCM sample width (signed)
//   OSR_WIDTH   width of the oversampling-ratio control
//
// Ports
//   i_clk           in  1             clock
//   i_rst_n         in  1             synchronous active-low reset
//   i_enable        in  1             run enable; low forces IDLE
//   i_osr           in  OSR_WIDTH     ticks per sample minus 1 (latched on load)
//   i_s_valid       in  1             input sample valid
//   o_s_ready       out 1             input sample ready
//   i_s_data        in  DATA_WIDTH    input sample, signed
//   i_fb_bit        in  1             quantizer bit: 1 => +full-scale, 0 => -full-scale
//   i_clr_underrun  in  1             clears o_underrun
//   o_en            out 1             integrator tick enable
//   o_data          out DATA_WIDTH+1  loop error, signed (combinational)
//   o_underrun      out 1             sticky: a period ended with no new sample
// -----------------------------------------------------------------------------
module dsm_sample_feeder
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OSR_WIDTH  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic [OSR_WIDTH-1:0]         i_osr,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic signed [DATA_WIDTH-1:0] i_s_data,
  input  logic                         i_fb_bit,
  input  logic                         i_clr_underrun,
  output logic                         o_en,
  output logic signed [DATA_WIDTH:0]   o_data,
  output logic                         o_underrun
);

  localparam logic signed [31:0]         FB_POS_32 = fb_pos(DATA_WIDTH);
  localparam logic signed [31:0]         FB_NEG_32 = fb_neg(DATA_WIDTH);
  localparam logic signed [DATA_WIDTH:0] FB_POS    = FB_POS_32[DATA_WIDTH:0];
  localparam logic signed [DATA_WIDTH:0] FB_NEG    = FB_NEG_32[DATA_WIDTH:0];
  localparam logic [OSR_WIDTH-1:0]       CNT_ONE   = OSR_WIDTH'(1);

  // One extra bit of headroom covers the full sample range minus either
  // feedback level, so no saturation is needed.
  function automatic logic signed [DATA_WIDTH:0] loop_err(
    input logic signed [DATA_WIDTH-1:0] sample,
    input logic                         fb
  );
    logic signed [DATA_WIDTH:0] sample_ext;
    sample_ext = {sample[DATA_WIDTH-1], sample};
    return sample_ext - (fb ? FB_POS : FB_NEG);
  endfunction

  dsm_state_t                  state_q, state_d;
  logic [OSR_WIDTH-1:0]        cnt_q, cnt_d;
  logic [OSR_WIDTH-1:0]        osr_q, osr_d;
  logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                        underrun_q, underrun_d;
  logic                        underrun_set;
  logic                        last_tick;
  logic                        accept;
  logic signed [DATA_WIDTH:0]  err;

  // Handshake
  assign last_tick = (state_q == RUN) && (cnt_q == osr_q);
  assign o_s_ready = i_enable && ((state_q == IDLE) || last_tick);
  assign accept    = i_s_valid && o_s_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      osr_q      <= '0;
      sample_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      osr_q      <= osr_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    osr_d        = osr_q;
    sample_d     = sample_q;
    underrun_set = 1'b0;

    if (!i_enable) begin
      // Disable wins over every RUN transition; the held sample survives.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sample_d = i_s_data;
            osr_d    = i_osr;
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (cnt_q != osr_q) begin
            cnt_d = cnt_q + CNT_ONE;
          end else if (accept) begin
            // Back-to-back reload keeps o_en continuous.
            sample_d = i_s_data;
            osr_d    = i_osr;
            cnt_d    = '0;
          end else begin
            // Starved: repeat the held sample for another period.
            cnt_d        = '0;
            underrun_set = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new underrun beats a simultaneous clear.
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (i_clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  assign o_en       = (state_q == RUN);
  assign o_underrun = underrun_q;
  assign err        = loop_err(sample_q, i_fb_bit);

`ifdef DSM_FEEDER_DITHER_EN
  logic dither;

  dsm_lfsr_dither u_dither (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (o_en),
    .o_dither (dither)
  );

  // Lowest reachable value is exactly -2^DATA_WIDTH, still representable.
  assign o_data = err - $signed({{DATA_WIDTH{1'b0}}, dither});
`else
  assign o_data = err;
`endif

endmodule

// File: tb/tb_dsm_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_dsm_sample_feeder
//   Directed bench for dsm_sample_feeder (DATA_WIDTH=16, OSR_WIDTH=8).
//   The stimulus process pushes the hand-computed loop error for every tick
//   it expects into exp_q; a monitor pops and compares on each cycle where
//   o_en is high. Control outputs are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_dsm_sample_feeder;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [7:0]         osr;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               fb_bit;
  logic               clr_underrun;
  logic               en;
  logic signed [16:0] data;
  logic               underrun;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  dsm_sample_feeder #(.DATA_WIDTH(16), .OSR_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_osr          (osr),
    .i_s_valid      (s_valid),
    .o_s_ready      (s_ready),
    .i_s_data       (s_data),
    .i_fb_bit       (fb_bit),
    .i_clr_underrun (clr_underrun),
    .o_en           (en),
    .o_data         (data),
    .o_underrun     (underrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

`ifdef DSM_FEEDER_DITHER_EN
  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed 0xACE1, advances per tick.
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else if (en) lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
`endif

  // Monitor: one expected loop error per tick.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: o_en=1 with o_data=%0d, expected no tick", data);
      end else begin
        int e;
        e = exp_q.pop_front();
`ifdef DSM_FEEDER_DITHER_EN
        e = e - int'(lfsr_m[0]);
`endif
        chk("o_data_tick", int'(data), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; osr = 8'd0; s_valid = 1'b0;
    s_data = '0; fb_bit = 1'b0; clr_underrun = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst_en", int'(en), 0);
`ifdef DSM_FEEDER_DITHER_EN
    chk("rst_data", int'(data), 32767);
`else
    chk("rst_data", int'(data), 32768);
`endif
    rst_n = 1'b1;
    tick();
    chk("rst_en_after", int'(en), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_ready", int'(s_ready), 1);

    // Single sample 0x1000, feedback flip mid-period
    s_valid = 1'b1; s_data = 16'sh1000; osr = 8'd3; fb_bit = 1'b0;
    push(36864, 2);
    push(-28671, 2);
    tick();
    s_valid = 1'b0;
    chk("t2_en_first", int'(en), 1);
    chk("t2_ready_cnt0", int'(s_ready), 0);
    tick();
    tick();
    fb_bit = 1'b1;
    tick();
    chk("t2_ready_last", int'(s_ready), 1);
    enable = 1'b0;
    tick();
    chk("t2_en_off", int'(en), 0);
    enable = 1'b1; fb_bit = 1'b0;

    // Back-to-back stream 100, 200
    s_valid = 1'b1; s_data = 16'sd100; osr = 8'd3;
    push(32868, 4);
    push(32968, 4);
    tick();
    s_data = 16'sd200;
    for (int k = 0; k < 3; k++) begin
      chk("t3_ready_mid", int'(s_ready), 0);
      chk("t3_en_p1", int'(en), 1);
      tick();
    end
    chk("t3_ready_last", int'(s_ready), 1);
    tick();
    s_valid = 1'b0;
    chk("t3_en_reload", int'(en), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_en_p2", int'(en), 1);
    end
    enable = 1'b0;
    chk("t3_underrun", int'(underrun), 0);
    tick();
    enable = 1'b1;
    chk("t3_underrun_end", int'(underrun), 0);

    // Underrun: sample repeated, set beats clear
    s_valid = 1'b1; s_data = 16'sd100; osr = 8'd3;
    push(32868, 9);
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    chk("t4_no_underrun_yet", int'(underrun), 0);
    tick();
    chk("t4_underrun_set", int'(underrun), 1);
    chk("t4_en_repeat", int'(en), 1);
    repeat (3) tick();
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("t4_set_wins", int'(underrun), 1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("t4_sticky", int'(underrun), 1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("t4_cleared", int'(underrun), 0);

    // Enable dropped at cnt=1
    s_valid = 1'b1; s_data = 16'sd300; osr = 8'd3; fb_bit = 1'b1;
    push(-32467, 2);
    tick();
    s_valid = 1'b0;
    tick();
    enable = 1'b0;
    #1;
    chk("t5_ready_disabled", int'(s_ready), 0);
    tick();
    chk("t5_en_off", int'(en), 0);
    chk("t5_ready_off", int'(s_ready), 0);
    enable = 1'b1;
    #1;
    chk("t5_ready_back", int'(s_ready), 1);
    fb_bit = 1'b0;

    // i_osr change mid-period, then a one-tick period
    s_valid = 1'b1; s_data = 16'sd50; osr = 8'd3;
    push(32818, 4);
    push(32828, 1);
    tick();
    s_valid = 1'b0;
    osr = 8'd0;
    tick();
    tick();
    chk("t6_ready_cnt2", int'(s_ready), 0);
    tick();
    s_valid = 1'b1; s_data = 16'sd60;
    tick();
    s_valid = 1'b0;
    chk("t6_en_osr0", int'(en), 1);
    chk("t6_ready_osr0", int'(s_ready), 1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("t6_en_off", int'(en), 0);

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
